// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply/divide unit for the execute stage.
// It produces one product or quotient bit per cycle into the HI/LO registers.
// A busy/done handshake lets the control path stall until the result is valid.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] readData1,
   input  logic [WIDTH-1:0] readData2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             divByZero
);

   localparam logic [5:0]  FUNCT_MULT = 6'b011000;
   localparam logic [5:0]  FUNCT_DIV  = 6'b011010;
   localparam int unsigned CW         = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand (mult) or divisor (div)
   logic [2*WIDTH-1:0] work_q, work_d;      // {upper, lower} shift-add / {rem, quo} restoring
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dbz_q, dbz_d;

   logic               idle_or_done;
   logic               is_mult, is_div;
   logic               accept;
   logic               last_iter;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_partial;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] mul_step, div_step;

   assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
   assign is_mult      = (funct == FUNCT_MULT);
   assign is_div       = (funct == FUNCT_DIV);
   assign accept       = start && idle_or_done && (is_mult || is_div);
   assign last_iter    = (cnt_q == CW'(WIDTH - 1));

   // One iteration of each algorithm, computed from the current work register
   always_comb begin
      // Shift-add: the multiplier sits in the lower half; its LSB selects the add,
      // and the carry out of the upper half is shifted back in from the top.
      mul_sum     = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
      mul_step    = {mul_sum, work_q[WIDTH-1:1]};
      // Restoring: shift the next dividend bit into the remainder, then trial-subtract.
      // The remainder is always below the divisor, so bit WIDTH of the difference is the borrow.
      div_partial = work_q[2*WIDTH-1:WIDTH-1];
      div_diff    = div_partial - {1'b0, opnd_q};
      div_step    = div_diff[WIDTH] ? {work_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
   end

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         opnd_q  <= '0;
         work_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
         work_q  <= work_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (is_mult)                state_d = S_MUL;
               else if (readData2 == '0)   state_d = S_DONE;
               else                        state_d = S_DIV;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL, S_DIV: begin
            if (last_iter) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: operand latch, iteration, and result commit
   always_comb begin
      cnt_d  = cnt_q;
      opnd_d = opnd_q;
      work_d = work_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      dbz_d  = dbz_q;
      if (accept) begin
         cnt_d = '0;
         dbz_d = 1'b0;
         if (is_mult) begin
            opnd_d = readData1;
            work_d = {{WIDTH{1'b0}}, readData2};
         end else if (readData2 == '0) begin
            hi_d  = readData1;
            lo_d  = '1;
            dbz_d = 1'b1;
         end else begin
            opnd_d = readData2;
            work_d = {{WIDTH{1'b0}}, readData1};
         end
      end else if ((state_q == S_MUL) || (state_q == S_DIV)) begin
         cnt_d  = cnt_q + CW'(1);
         work_d = (state_q == S_MUL) ? mul_step : div_step;
         if (last_iter) begin
            hi_d = work_d[2*WIDTH-1:WIDTH];
            lo_d = work_d[WIDTH-1:0];
         end
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      busy      = (state_q == S_MUL) || (state_q == S_DIV);
      done      = (state_q == S_DONE);
      hi        = hi_q;
      lo        = lo_q;
      divByZero = dbz_q;
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// It uses hand-computed results and checks them with immediate assertions.
module tb_mult_div_unit;

   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_DIV  = 6'b011010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] readData1 = '0;
   logic [31:0] readData2 = '0;
   logic        busy, done, divByZero;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct(funct),
      .readData1(readData1), .readData2(readData2),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .divByZero(divByZero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle (to the next falling edge) and tally the handshake outputs
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
   endtask

   // Present a request for exactly one rising edge
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; funct = f; readData1 = a; readData2 = b;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      busy_cnt = busy ? 1 : 0;
      done_cnt = 0;
   endtask

   task automatic wait_done();
      while (!done && cyc < 40) step(1);
   endtask

   initial begin
      // Reset, including a start presented in the same cycle as rst
      rst = 1'b1;
      step(2);
      start = 1'b1; funct = F_MULT; readData1 = 32'd3; readData2 = 32'd3;
      step(1);
      start = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi",   64'(hi),   64'd0);
      chk("rst_lo",   64'(lo),   64'd0);
      chk("rst_dbz",  64'(divByZero), 64'd0);
      rst = 1'b0;
      step(1);

      // Unsupported funct in IDLE is ignored
      issue(6'b100000, 32'd9, 32'd9);
      chk("badf_busy", 64'(busy), 64'd0);
      chk("badf_done", 64'(done), 64'd0);
      step(1);
      chk("badf_lo", 64'(lo), 64'd0);

      // Small mult
      issue(F_MULT, 32'd7, 32'd6);
      wait_done();
      chk("m7x6_lat",  64'(cyc), 64'd32);
      chk("m7x6_busy", 64'(busy_cnt), 64'd32);
      chk("m7x6_hi",   64'(hi), 64'd0);
      chk("m7x6_lo",   64'(lo), 64'd42);
      chk("m7x6_dbz",  64'(divByZero), 64'd0);
      step(1);
      chk("m7x6_pulse", 64'(done), 64'd0);
      chk("m7x6_hold",  64'(lo), 64'd42);

      // Full-width mult
      issue(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done();
      chk("mfull_lat", 64'(cyc), 64'd32);
      chk("mfull_hi",  64'(hi), 64'hFFFF_FFFE);
      chk("mfull_lo",  64'(lo), 64'h0000_0001);
      step(1);

      // Division, then a back-to-back start during the done cycle
      issue(F_DIV, 32'd100, 32'd7);
      wait_done();
      chk("d100_lat", 64'(cyc), 64'd32);
      chk("d100_lo",  64'(lo), 64'd14);
      chk("d100_hi",  64'(hi), 64'd2);
      issue(F_DIV, 32'hFFFF_FFFF, 32'h10);
      chk("b2b_done", 64'(done), 64'd0);
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_hold", {hi, lo}, {32'd2, 32'd14});
      wait_done();
      chk("b2b_lat", 64'(cyc), 64'd32);
      chk("b2b_lo",  64'(lo), 64'h0FFF_FFFF);
      chk("b2b_hi",  64'(hi), 64'hF);
      step(1);

      // Dividend smaller than divisor
      issue(F_DIV, 32'd3, 32'd10);
      wait_done();
      chk("dsmall", {hi, lo}, {32'd3, 32'd0});
      step(1);

      // Divide by zero: result on the accepting edge, done the next cycle
      issue(F_DIV, 32'd5, 32'd0);
      chk("dz_done", 64'(done), 64'd1);
      chk("dz_busy", 64'(busy), 64'd0);
      chk("dz_hi",   64'(hi), 64'd5);
      chk("dz_lo",   64'(lo), 64'hFFFF_FFFF);
      chk("dz_flag", 64'(divByZero), 64'd1);
      step(1);
      chk("dz_pulse", 64'(done), 64'd0);
      chk("dz_stick", 64'(divByZero), 64'd1);
      issue(F_MULT, 32'd3, 32'd5);
      chk("dz_clear", 64'(divByZero), 64'd0);
      wait_done();
      chk("m3x5_lo", 64'(lo), 64'd15);
      step(1);

      // A second mult start mid-operation is ignored
      issue(F_MULT, 32'h0001_0000, 32'h0003_0000);
      step(4);
      start = 1'b1; funct = F_MULT; readData1 = 32'd9; readData2 = 32'd9;
      step(1);
      start = 1'b0;
      wait_done();
      chk("ign_lat",  64'(cyc), 64'd32);
      chk("ign_busy", 64'(busy_cnt), 64'd32);
      chk("ign_res",  {hi, lo}, 64'h0000_0003_0000_0000);
      step(1);

      // Reset mid-operation aborts with no done pulse
      issue(F_MULT, 32'd11, 32'd13);
      step(9);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      done_cnt = 0;
      step(35);
      chk("abort_nodone", 64'(done_cnt), 64'd0);
      issue(F_MULT, 32'h0000_FFFF, 32'h0000_FFFF);
      wait_done();
      chk("post_lat", 64'(cyc), 64'd32);
      chk("post_res", {hi, lo}, 64'h0000_0000_FFFE_0001);
      step(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit unsigned multiply/divide unit for the MIPS execute stage. It sits beside the combinational ALU, fed from the same register-file operands (readData1, readData2) and R-type funct field. It computes mult (funct 011000) and div (funct 011010) over multiple cycles, one bit per cycle, instead of with single-cycle `*` and `/`. Results land in HI/LO registers, and a busy/done handshake lets the control path stall until they are valid.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled on rising clk
- funct  input  6  R-type function code; 011000 = mult, 011010 = div
- readData1  input  WIDTH  multiplicand / dividend
- readData2  input  WIDTH  multiplier / divisor
- busy  output  1  high while an operation iterates
- done  output  1  one-cycle pulse when hi/lo hold a new result
- hi  output  WIDTH  mult: upper product half; div: remainder
- lo  output  WIDTH  mult: lower product half; div: quotient
- divByZero  output  1  high when the last completed div had divisor 0

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset: state IDLE; busy=0, done=0, hi=0, lo=0, divByZero=0; iteration counter 0.
- Acceptance: a start is accepted when start=1 in IDLE or DONE and funct is 011000 or 011010.
  - Operands and funct are latched at acceptance.
  - divByZero clears at every accepted start.
- Ignored starts, with no state change:
  - start with any other funct;
  - start while in MUL or DIV.
- MUL: unsigned shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH iterations.
  - On the last iteration, {hi,lo} is loaded with the full 64-bit product. No truncation.
- DIV: unsigned restoring division, one quotient bit per cycle, WIDTH iterations.
  - On the last iteration, lo = quotient and hi = remainder.
- Divide by zero (readData2 == 0 at acceptance):
  - no iteration; next state DONE;
  - hi = readData1, lo = all ones, divByZero = 1.
- DONE: lasts one cycle, then returns to IDLE unless a new start is accepted in that cycle.
- hi/lo change only at completion or reset. They hold their value across IDLE, ignored starts and in-progress operations.
- Reset mid-operation aborts the operation: all outputs take their reset values on that edge, and no done pulse is produced.
- busy = (state is MUL or DIV). done = (state is DONE). Both come from registered state, with no combinational path from any input.

## Timing
- Edge E0 accepts start. busy=1 from E0 until E32.
- Iterations occur on edges E1..E32.
- On E32: hi/lo are written, state becomes DONE, busy=0, done=1 for exactly one cycle.
- Latency: done is visible 32 cycles after the accepting edge; hi/lo are valid in the same cycle as done.
- Divide by zero: hi/lo/divByZero are written on E0; done=1 on the next cycle (latency 1).
- Back-to-back: a start accepted while in DONE begins the next operation on that edge, and done deasserts. Throughput is one result per 33 cycles.
- A start arriving simultaneously with rst is ignored; reset wins.

## Test plan
- Small mult: mult, readData1=7, readData2=6 -> busy high 32 cycles; done pulses once; hi=0, lo=42; divByZero=0.
- Full-width mult: mult, 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Division and back-to-back start: div 100 / 7 -> lo=14, hi=2. Then assert div 0xFFFFFFFF / 0x10 during the done cycle -> accepted; lo=0x0FFFFFFF, hi=0xF.
- Divide by zero: div 5 / 0 -> done one cycle after acceptance; hi=5, lo=0xFFFFFFFF, divByZero=1. The next accepted mult clears divByZero.
- Ignored starts: start with funct 100000 in IDLE, and a second mult start at iteration 5 -> no state change, and the running result is unaffected.
- Reset mid-operation: rst asserted at iteration 10 of a mult -> next cycle state IDLE, busy=0, hi=lo=0, no done pulse. A new mult afterwards completes correctly.
